// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath selects.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal instructions enter a sticky TRAP state;
// when undefined they retire as a NOP from DECODE and trap is tied 0).
module multicycle_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  eq,
   input  logic                  mem_ready,
   output logic [2:0]            ALUctrl,
   output logic [1:0]            ALUsrcA,
   output logic [1:0]            ALUsrcB,
   output logic [1:0]            ImmSrc,
   output logic [1:0]            ResultSrc,
   output logic                  AdrSrc,
   output logic                  mem_req,
   output logic                  MemWrite,
   output logic                  IRwrite,
   output logic                  PCwrite,
   output logic                  RegWrite,
   output logic                  instr_done,
   output logic                  trap
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic [2:0] exec_op;
   logic       alu_ok;
   logic       legal;
   logic       unused_instr;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7b5 = instr[30];
   // Register and immediate fields are consumed by the datapath, not the controller.
   assign unused_instr = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

   // Instruction legality and the ALU operation used in EXECR/EXECI.
   always_comb begin
      exec_op = ALU_ADD;
      alu_ok  = 1'b1;
      legal   = 1'b0;
      case (funct3)
         3'b000:  exec_op = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  exec_op = ALU_SLT;
         3'b110:  exec_op = ALU_OR;
         3'b111:  exec_op = ALU_AND;
         default: alu_ok  = 1'b0;
      endcase
      case (opcode)
         OP_R, OP_I:   legal = alu_ok;
         OP_LW, OP_SW: legal = (funct3 == 3'b010);
         OP_BR:        legal = (funct3[2:1] == 2'b00);
         OP_JAL:       legal = 1'b1;
         default:      legal = 1'b0;
      endcase
   end

   // State register; reset aborts any instruction in flight and restarts at FETCH.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Moore outputs and next state; everything is held at 0 while reset is low.
   always_comb begin
      state_d    = state_q;
      ALUctrl    = ALU_ADD;
      ALUsrcA    = 2'b00;
      ALUsrcB    = 2'b00;
      ImmSrc     = 2'b00;
      ResultSrc  = 2'b00;
      AdrSrc     = 1'b0;
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRwrite    = 1'b0;
      PCwrite    = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      trap       = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               ALUsrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRwrite   = mem_ready;
               PCwrite   = mem_ready;
               if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
               // Branch target is precomputed here into ALUout.
               ALUsrcA = 2'b01;
               ALUsrcB = 2'b01;
               ImmSrc  = 2'b10;
               if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
                  state_d = S_TRAP;
`else
                  state_d    = S_FETCH;
                  instr_done = 1'b1;
`endif
               end else begin
                  case (opcode)
                     OP_LW, OP_SW: state_d = S_MEMADR;
                     OP_R:         state_d = S_EXECR;
                     OP_I:         state_d = S_EXECI;
                     OP_BR:        state_d = S_BRANCH;
                     OP_JAL:       state_d = S_JAL;
                     default:      state_d = S_FETCH;
                  endcase
               end
            end
            S_MEMADR: begin
               ALUsrcA = 2'b10;
               ALUsrcB = 2'b01;
               ImmSrc  = (opcode == OP_SW) ? 2'b01 : 2'b00;
               state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
               if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
               ResultSrc  = 2'b01;
               RegWrite   = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
               mem_req    = 1'b1;
               MemWrite   = 1'b1;
               AdrSrc     = 1'b1;
               instr_done = mem_ready;
               if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
               ALUsrcA = 2'b10;
               ALUsrcB = 2'b00;
               ALUctrl = exec_op;
               state_d = S_ALUWB;
            end
            S_EXECI: begin
               ALUsrcA = 2'b10;
               ALUsrcB = 2'b01;
               ImmSrc  = 2'b00;
               ALUctrl = exec_op;
               state_d = S_ALUWB;
            end
            S_ALUWB: begin
               ResultSrc  = 2'b00;
               RegWrite   = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_BRANCH: begin
               // funct3[0] distinguishes bne (taken on !eq) from beq.
               ALUsrcA    = 2'b10;
               ALUsrcB    = 2'b00;
               ALUctrl    = ALU_SUB;
               PCwrite    = eq ^ funct3[0];
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_JAL: begin
               ALUsrcA = 2'b01;
               ALUsrcB = 2'b10;
               PCwrite = 1'b1;
               state_d = S_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
               trap = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations come from a
// table-level model of the instruction set (latency, write pulses, ALU op, selects).
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        eq = 1'b0;
   logic        mem_ready = 1'b0;
   logic [2:0]  ALUctrl;
   logic [1:0]  ALUsrcA, ALUsrcB, ImmSrc, ResultSrc;
   logic        AdrSrc, mem_req, MemWrite, IRwrite, PCwrite, RegWrite, instr_done, trap;

   multicycle_ctrl #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .eq(eq), .mem_ready(mem_ready),
      .ALUctrl(ALUctrl), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ImmSrc(ImmSrc),
      .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .mem_req(mem_req), .MemWrite(MemWrite),
      .IRwrite(IRwrite), .PCwrite(PCwrite), .RegWrite(RegWrite),
      .instr_done(instr_done), .trap(trap)
   );

   always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP_BUILD = 1'b1;
`else
   localparam bit TRAP_BUILD = 1'b0;
`endif

   // Expected retirement record. 7 for alu/srcb/imm means "no rs1-based ALU cycle".
   typedef struct {
      logic [31:0] ins;
      int cycles;
      int regw;
      int pcw;
      int memw;
      int alu;
      int srcb;
      int imm;
      int wbsrc;
   } exp_t;

   exp_t expq[$];
   int   waitq[$];
   int   checks = 0;
   int   failures = 0;
   int   retired = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit is_legal(input logic [31:0] i);
      logic [2:0] f3;
      f3 = i[14:12];
      case (i[6:0])
         7'h33, 7'h13: return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
         7'h03, 7'h23: return (f3 == 3'd2);
         7'h63:        return (f3 == 3'd0 || f3 == 3'd1);
         7'h6F:        return 1'b1;
         default:      return 1'b0;
      endcase
   endfunction

   // Behaviour of one instruction given fetch wait wf, data wait wm and eq value.
   function automatic exp_t model(input logic [31:0] i, input int wf, input int wm, input logic e);
      exp_t x;
      logic [2:0] f3;
      f3 = i[14:12];
      x.ins = i; x.regw = 0; x.pcw = 1; x.memw = 0;
      x.alu = 7; x.srcb = 7; x.imm = 7; x.wbsrc = 7;
      if (!is_legal(i)) begin
         x.cycles = 2 + wf;
      end else begin
         case (i[6:0])
            7'h33, 7'h13: begin
               x.cycles = 4 + wf; x.regw = 1; x.wbsrc = 0;
               case (f3)
                  3'd0:    x.alu = (i[6:0] == 7'h33 && i[30]) ? 1 : 0;
                  3'd2:    x.alu = 5;
                  3'd6:    x.alu = 3;
                  default: x.alu = 2;
               endcase
               x.srcb = (i[6:0] == 7'h33) ? 0 : 1;
               x.imm  = (i[6:0] == 7'h33) ? 7 : 0;
            end
            7'h03: begin
               x.cycles = 5 + wf + wm; x.regw = 1; x.wbsrc = 1;
               x.alu = 0; x.srcb = 1; x.imm = 0;
            end
            7'h23: begin
               x.cycles = 4 + wf + wm; x.memw = wm + 1;
               x.alu = 0; x.srcb = 1; x.imm = 1;
            end
            7'h63: begin
               x.cycles = 3 + wf; x.alu = 1; x.srcb = 0;
               if ((f3 == 3'd0) ? e : !e) x.pcw = 2;
            end
            default: begin
               x.cycles = 4 + wf; x.regw = 1; x.pcw = 2; x.wbsrc = 0;
            end
         endcase
      end
      return x;
   endfunction

   // Issue one instruction and wait (bounded) for the monitor to see it retire.
   task automatic issue(input logic [31:0] i, input int wf, input int wm, input logic e);
      int start;
      int t;
      start = retired;
      t = 0;
      instr = i;
      eq = e;
      waitq.push_back(wf);
      if (is_legal(i) && (i[6:0] == 7'h03 || i[6:0] == 7'h23)) waitq.push_back(wm);
      expq.push_back(model(i, wf, wm, e));
      while (retired == start && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (retired == start) begin
         checks++;
         failures++;
         $display("FAIL retire_timeout instr=%08h actual=none required=instr_done", i);
      end
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0: r[6:0] = 7'h33;
         1: r[6:0] = 7'h13;
         2: r[6:0] = 7'h03;
         3: r[6:0] = 7'h23;
         4: r[6:0] = 7'h63;
         5: r[6:0] = 7'h6F;
         default: r[6:0] = 7'h37;
      endcase
      if ($urandom_range(0, 3) != 0) begin
         case (r[6:0])
            7'h33, 7'h13: begin
               case ($urandom_range(0, 3))
                  0: r[14:12] = 3'd0;
                  1: r[14:12] = 3'd2;
                  2: r[14:12] = 3'd6;
                  default: r[14:12] = 3'd7;
               endcase
            end
            7'h03, 7'h23: r[14:12] = 3'd2;
            7'h63:        r[14:12] = {2'b00, r[12]};
            default: ;
         endcase
      end
      return r;
   endfunction

   // Memory responder: each request takes the next queued wait count; ready is random when idle.
   initial begin : responder
      int rem;
      bit busy;
      rem = 0;
      busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            busy = 1'b0;
            mem_ready = 1'b0;
         end else if (mem_req) begin
            if (!busy) begin
               busy = 1'b1;
               rem = (waitq.size() > 0) ? waitq.pop_front() : 0;
            end
            if (rem == 0) begin
               mem_ready = 1'b1;
               busy = 1'b0;
            end else begin
               mem_ready = 1'b0;
               rem--;
            end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: accumulate per-instruction activity and score it on instr_done.
   initial begin : monitor
      int cyc, rw, pw, mw, irw, alu_seen, srcb_seen, imm_seen, wb_seen;
      bit was_wait, after_rst;
      logic prev_adr, prev_mw;
      exp_t x;
      cyc = 0; rw = 0; pw = 0; mw = 0; irw = 0;
      alu_seen = 7; srcb_seen = 7; imm_seen = 7; wb_seen = 7;
      was_wait = 1'b0; after_rst = 1'b1; prev_adr = 1'b0; prev_mw = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("reset_outputs_zero",
                {13'd0, ALUctrl, ALUsrcA, ALUsrcB, ImmSrc, ResultSrc, AdrSrc, mem_req,
                 MemWrite, IRwrite, PCwrite, RegWrite, instr_done, trap}, 32'd0);
            cyc = 0; rw = 0; pw = 0; mw = 0; irw = 0;
            alu_seen = 7; srcb_seen = 7; imm_seen = 7; wb_seen = 7;
            was_wait = 1'b0; after_rst = 1'b1;
         end else if (!trap) begin
            if (after_rst) begin
               chk("first_mem_req_after_reset", {31'd0, mem_req}, 32'd1);
               after_rst = 1'b0;
            end
            if (was_wait) begin
               chk("handshake_req_held", {31'd0, mem_req}, 32'd1);
               chk("handshake_adr_held", {31'd0, AdrSrc}, {31'd0, prev_adr});
               chk("handshake_we_held", {31'd0, MemWrite}, {31'd0, prev_mw});
            end
            was_wait = mem_req && !mem_ready;
            prev_adr = AdrSrc;
            prev_mw  = MemWrite;
            cyc++;
            if (RegWrite) begin rw++; wb_seen = ResultSrc; end
            if (PCwrite) pw++;
            if (MemWrite) mw++;
            if (IRwrite) begin
               irw++;
               chk("fetch_selects", {25'd0, AdrSrc, ALUsrcA, ALUsrcB, ResultSrc}, {25'd0, 1'b0, 2'b00, 2'b10, 2'b10});
            end
            if (ALUsrcA == 2'b10) begin
               alu_seen = ALUctrl;
               srcb_seen = ALUsrcB;
               if (ALUsrcB == 2'b01) imm_seen = ImmSrc;
            end
            if (instr_done) begin
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_retire actual=instr_done required=none");
               end else begin
                  x = expq.pop_front();
                  chk($sformatf("cycles_%08h", x.ins), cyc, x.cycles);
                  chk($sformatf("regwrite_%08h", x.ins), rw, x.regw);
                  chk($sformatf("pcwrite_%08h", x.ins), pw, x.pcw);
                  chk($sformatf("memwrite_%08h", x.ins), mw, x.memw);
                  chk($sformatf("irwrite_%08h", x.ins), irw, 1);
                  chk($sformatf("aluctrl_%08h", x.ins), alu_seen, x.alu);
                  chk($sformatf("alusrcb_%08h", x.ins), srcb_seen, x.srcb);
                  chk($sformatf("immsrc_%08h", x.ins), imm_seen, x.imm);
                  chk($sformatf("resultsrc_wb_%08h", x.ins), wb_seen, x.wbsrc);
                  chk($sformatf("trap_low_%08h", x.ins), {31'd0, trap}, 32'd0);
               end
               cyc = 0; rw = 0; pw = 0; mw = 0; irw = 0;
               alu_seen = 7; srcb_seen = 7; imm_seen = 7; wb_seen = 7;
               retired++;
            end
         end
      end
   end

   typedef struct {
      logic [31:0] ins;
      int          wf;
      int          wm;
      logic        e;
   } dir_t;

   // Stimulus: directed vectors, randomized stream, reset abort, illegal handling.
   initial begin : stimulus
      dir_t dirs[$];
      logic [31:0] ri;
      dirs.push_back('{32'h002081B3, 0, 0, 1'b0});
      dirs.push_back('{32'h402081B3, 0, 0, 1'b0});
      dirs.push_back('{32'h0020A1B3, 0, 0, 1'b0});
      dirs.push_back('{32'h00A0E093, 0, 0, 1'b0});
      dirs.push_back('{32'h0040A183, 0, 3, 1'b0});
      dirs.push_back('{32'h0030A223, 0, 0, 1'b0});
      dirs.push_back('{32'h00208463, 0, 0, 1'b1});
      dirs.push_back('{32'h00208463, 0, 0, 1'b0});
      dirs.push_back('{32'h00209463, 0, 0, 1'b1});
      dirs.push_back('{32'h00209463, 0, 0, 1'b0});
      dirs.push_back('{32'h008000EF, 0, 0, 1'b0});
      dirs.push_back('{32'h002081B3, 2, 0, 1'b0});
      dirs.push_back('{32'h0030A223, 1, 2, 1'b0});
      if (!TRAP_BUILD) dirs.push_back('{32'hFFFFFFFF, 0, 0, 1'b0});

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (dirs[k]) issue(dirs[k].ins, dirs[k].wf, dirs[k].wm, dirs[k].e);

      for (int n = 0; n < 200; n++) begin
         ri = rand_instr();
         while (TRAP_BUILD && !is_legal(ri)) ri = rand_instr();
         issue(ri, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Reset during a stalled store: the store is abandoned without retiring.
      instr = 32'h0030A223;
      waitq.push_back(0);
      waitq.push_back(20);
      repeat (5) @(posedge clk);
      #1;
      chk("store_waiting_before_reset", {30'd0, mem_req, MemWrite}, 32'd3);
      rst_n = 1'b0;
      waitq.delete();
      expq.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(32'h002081B3, 0, 0, 1'b0);
      issue(32'h0040A183, 1, 1, 1'b0);

      if (TRAP_BUILD) begin
         instr = 32'hFFFFFFFF;
         waitq.push_back(0);
         repeat (2) @(posedge clk);
         #1;
         chk("trap_set", {31'd0, trap}, 32'd1);
         repeat (5) @(posedge clk);
         #1;
         chk("trap_sticky", {30'd0, trap, mem_req}, 32'd2);
         rst_n = 1'b0;
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         #1;
         chk("trap_cleared", {31'd0, trap}, 32'd0);
         issue(32'h00A0E093, 0, 0, 1'b0);
      end

      chk("scoreboard_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
